mux_rr: RTL
===========

# mux_rr

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a one-beat output register. It is the next generation of the team's 4:1 combinational mux. A runtime mode selects between explicit channel select (classic mux behaviour) and round-robin arbitration across all valid channels. It sits between multiple producers and a single downstream consumer.

## Interface
- N, default 4: number of input channels (2..16).
- W, default 8: data width per channel.
- SW, default $clog2(N): select/channel-index width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational, at most one bit high.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- out_data  output  W  registered output data.
- out_chan  output  SW  index of the channel that produced out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

## Operation
- The output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid || out_ready. Arbitration happens only in cycles where load_en=1.
- Mode 0:
  - The candidate is sel. A grant occurs if sel < N and in_valid[sel]=1.
  - If sel >= N (non-power-of-2 N), there is never a grant.
- Mode 1:
  - The candidate is the first channel with in_valid=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - A grant occurs if any in_valid bit is set.
- in_ready[g] = load_en && grant && (g = granted channel). All other in_ready bits are 0.
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. On a transfer:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1. ptr advances in both modes.
- If load_en=1 and there is no grant: out_valid <= 0, and out_data/out_chan hold their previous values.
- If load_en=0 (FULL and out_ready=0): all registers hold and in_ready = 0.
- Changes to mode and sel take effect in the same cycle's arbitration; no pipeline applies to them.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_chan=0, ptr=0.
  - in_ready is forced to all-zero while rst_n=0.
- Latency: one cycle from an input transfer to the beat appearing on out_data/out_valid.
- Throughput: one beat per cycle while out_ready=1 and requests are present.
- Simultaneous out_ready=1 and a new grant while FULL: the old beat is consumed and the new beat is loaded at the same edge, with no bubble.
- Backpressure: out_data and out_chan are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-transfer: the held beat is discarded and all outputs go to reset values immediately. The first grant after release searches from channel 0.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive grants.

## Test plan
- Reset: rst_n=0 with in_valid=4'b1111 and out_ready=1.
  - Required: out_valid=0, out_data=8'h00, out_chan=0, in_ready=4'b0000 during reset.
  - After release in mode 1: the first grant is channel 0.
- Mode 0 sweep: N=4, W=8, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=4'b1111, out_ready=1, sel=0,1,2,3 on consecutive cycles.
  - Required: out_data 8'h11, 8'h22, 8'h33, 8'h44 one cycle later, with out_chan matching sel.
  - Required: in_ready one-hot at bit sel each cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1.
  - Required: grants go to 0,1,2,3,0,1 on consecutive cycles, out_valid stays high, and there are no bubbles.
- Backpressure: with out_valid=1 (out_data=8'h22), hold out_ready=0 for 3 cycles.
  - Required: out_data stays 8'h22 and in_ready=4'b0000 throughout.
  - Then set out_ready=1: channel 2 is granted in that same cycle and out_data=8'h33 on the next cycle.
- Sparse and wrap-around: mode=1, ptr=3 after a grant to channel 2, in_valid=4'b0101.
  - Required: channel 0 is granted (the search wraps 3→0), then channel 2 on the next cycle.
  - With in_valid=4'b0000: out_valid drops to 0 after the last beat is consumed.
- Mode 0 with an invalid channel: sel=1 and in_valid[1]=0 while other channels are valid.
  - Required: no grant, in_ready=4'b0000, and out_valid deasserts once the held beat is consumed.

Source files
------------

// File: rtl/mux_rr.sv
// Purpose: N-channel W-bit mux with explicit-select or round-robin arbitration into a one-beat output register.
// Latency: one cycle from an input transfer to the beat on out_data/out_valid.
// Backpressure: the register reloads only when empty or being drained; in_ready is all-zero while a beat is stalled.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    N packed W-bit channels (channel c at [c*W +: W]) with per-channel valid
//   in_ready            combinational per-channel accept, at most one bit high
//   mode, sel           0 = take channel sel, 1 = round-robin over valid channels
//   out_data/out_chan   registered beat and the channel it came from
//   out_valid/out_ready output handshake
module mux_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic          load_en;
  logic          sel_gnt;
  logic          rr_gnt;
  logic [SW-1:0] rr_chan;
  logic [SW:0]   rr_idx;
  logic          grant;
  logic [SW-1:0] gnt_chan;
  logic [W-1:0]  gnt_data;
  logic          xfer;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    // Explicit select: a sel value at or beyond N matches no channel, so never grants.
    sel_gnt = 1'b0;
    for (int g = 0; g < N; g++) begin
      if (sel == SW'(g)) sel_gnt = in_valid[g];
    end

    // Round-robin: walk ptr, ptr+1, ... with wrap; the first valid channel wins.
    rr_gnt  = 1'b0;
    rr_chan = '0;
    rr_idx  = '0;
    for (int k = 0; k < N; k++) begin
      rr_idx = {1'b0, ptr} + (SW+1)'(k);
      if (rr_idx >= (SW+1)'(N)) rr_idx = rr_idx - (SW+1)'(N);
      if (!rr_gnt && in_valid[rr_idx[SW-1:0]]) begin
        rr_gnt  = 1'b1;
        rr_chan = rr_idx[SW-1:0];
      end
    end

    grant    = mode ? rr_gnt  : sel_gnt;
    gnt_chan = mode ? rr_chan : sel;

    gnt_data = '0;
    for (int g = 0; g < N; g++) begin
      if (gnt_chan == SW'(g)) gnt_data = in_data[g*W +: W];
    end
  end

  assign xfer = load_en && grant;

  // rst_n gates the accepts so no producer sees a handshake while the block is held in reset.
  always_comb begin
    in_ready = '0;
    for (int g = 0; g < N; g++) begin
      in_ready[g] = rst_n && xfer && (gnt_chan == SW'(g));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_chan  <= gnt_chan;
        // Pointer tracks the last winner in both modes so a switch to round-robin stays fair.
        ptr       <= (gnt_chan == SW'(N-1)) ? '0 : gnt_chan + SW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
